ttt_turn_controller: RTL and testbench
======================================

Name: ttt_turn_controller

Overview:
Sequencing controller for the tic-tac-toe board. It owns the board registers. It accepts one move request at a time, validates the move against the current board and writes the current player's mark. It then checks for a win or a draw and either passes the turn or ends the game. It sits between the debounced user-input logic (switches/keys) and the display logic, which reads the board and status outputs.

Parameters:
FIRST_PLAYER, 1, player who moves first after reset/new game (1 = X, 2 = O)
TIMEOUT_CYCLES, 0, clock cycles allowed per turn before forfeiting it; 0 disables the timeout

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
new_game  input  1  synchronous clear-and-restart request, level sampled each cycle
move_valid  input  1  one-cycle move request strobe
move_pos  input  4  target cell 0..8, row-major (0 top-left, 8 bottom-right)
board  output  18  cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O
current_player  output  2  player to move: 01 X, 10 O
winner  output  2  00 none, 01 X, 10 O
draw  output  1  board full with no winner
game_over  output  1  game finished (win or draw)
move_ack  output  1  one-cycle pulse: move accepted
move_err  output  1  one-cycle pulse: move rejected
turn_timeout  output  1  one-cycle pulse: turn forfeited by timeout

Behaviour:
- One clock domain. Reset is asynchronous and active-low. It is asserted when reset = 0, takes effect immediately and is released synchronously to clk.
- Reset values: board = 0, current_player = FIRST_PLAYER, winner = 0, draw = 0, game_over = 0, all pulses 0, move_count = 0, timer = 0, state = WAIT_MOVE.
- States: WAIT_MOVE, CHECK, OVER.
- WAIT_MOVE with move_valid = 1:
  - Legal move (move_pos <= 8 and the cell is 00): write current_player into the cell, increment move_count, assert move_ack in the next cycle, go to CHECK.
  - Otherwise: assert move_err in the next cycle, leave the board unchanged, stay in WAIT_MOVE.
- CHECK (exactly one cycle): evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) on the updated board.
  - Any line holds three equal non-empty marks: winner = current_player, game_over = 1, go to OVER. current_player is not toggled.
  - Else, if move_count = 9: draw = 1, game_over = 1, go to OVER.
  - Else: toggle current_player (01 <-> 10), clear timer, go to WAIT_MOVE.
- move_valid is ignored while in CHECK, with no ack and no err. Requesters must wait for move_ack or move_err before issuing the next move.
- OVER: every move_valid produces move_err. The board and status outputs hold until new_game or reset.
- Timeout, active only when TIMEOUT_CYCLES > 0:
  - The timer counts cycles in WAIT_MOVE and is cleared on every turn change.
  - When timer reaches TIMEOUT_CYCLES-1 with no move_valid that cycle: pulse turn_timeout, toggle current_player, clear timer, leave the board unchanged.
  - A move_valid in the same cycle as expiry takes priority; the timeout does not fire.
  - A rejected move does not clear the timer.
- new_game = 1, in any state:
  - Next cycle: same values as reset, except the pulses, which are 0.
  - new_game has priority over move_valid and over the timeout in the same cycle.
- Latency:
  - move_valid to move_ack/move_err: 1 cycle.
  - move_valid to updated board: 1 cycle.
  - move_valid to winner/game_over/turn change: 2 cycles.
- Widths: move_count is 4 bits and saturates at 9. The timer width is ceil(log2(TIMEOUT_CYCLES+1)), minimum 1.

Test Plan:
- Reset then release → board = 0, current_player = 01, game_over = 0. Move at pos 4 → move_ack; board[9:8] = 01; two cycles later current_player = 10.
- X moves to 0, 1, 2 and O moves to 3, 4, interleaved → after X's move to 2: winner = 01, game_over = 1, current_player stays 01. A further move at 5 → move_err, board unchanged.
- Full-board sequence X 0, O 1, X 2, O 4, X 3, O 5, X 7, O 6, X 8 → draw = 1, winner = 00, game_over = 1 after the 9th move.
- Move to an occupied cell, and a move with move_pos = 9 or 15 → move_err each time, board and current_player unchanged.
- TIMEOUT_CYCLES = 4, no input for 4 cycles → turn_timeout pulses once, current_player toggles. move_valid on the expiry cycle → move_ack and no timeout.
- new_game asserted in the same cycle as move_valid mid-game, then reset pulled low during CHECK → board cleared, no move_ack; after reset all outputs hold their reset values.

Source files
------------

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: owns the board, validates and applies moves,
// detects win/draw, passes the turn and optionally forfeits idle turns.
module ttt_turn_controller #(
  parameter int FIRST_PLAYER   = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [3:0]  move_pos,
  output logic [17:0] board,
  output logic [1:0]  current_player,
  output logic [1:0]  winner,
  output logic        draw,
  output logic        game_over,
  output logic        move_ack,
  output logic        move_err,
  output logic        turn_timeout
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [1:0] P_FIRST = (FIRST_PLAYER == 2) ? 2'b10 : 2'b01;

  typedef enum logic [1:0] {
    WAIT_MOVE = 2'd0,
    CHECK     = 2'd1,
    OVER      = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [17:0]      board_nxt;
  logic [1:0]       cur_nxt, winner_nxt, cell_sel;
  logic             draw_nxt, over_nxt, ack_nxt, err_nxt, to_nxt, legal;
  logic [3:0]       move_count, cnt_nxt;
  logic [TMR_W-1:0] timer, tmr_nxt;

  function automatic logic same3(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c);
    return (a != 2'b00) && (a == b) && (b == c);
  endfunction

  function automatic logic any_line(input logic [17:0] b);
    logic [1:0] c [9];
    for (int i = 0; i < 9; i++) c[i] = b[2*i +: 2];
    return same3(c[0], c[1], c[2]) | same3(c[3], c[4], c[5]) |
           same3(c[6], c[7], c[8]) | same3(c[0], c[3], c[6]) |
           same3(c[1], c[4], c[7]) | same3(c[2], c[5], c[8]) |
           same3(c[0], c[4], c[8]) | same3(c[2], c[4], c[6]);
  endfunction

  function automatic logic [1:0] other(input logic [1:0] p);
    return (p == 2'b01) ? 2'b10 : 2'b01;
  endfunction

  // Next-state and next-value logic for the sequencer and its registers
  always_comb begin
    state_nxt  = state;
    board_nxt  = board;
    cur_nxt    = current_player;
    winner_nxt = winner;
    draw_nxt   = draw;
    over_nxt   = game_over;
    cnt_nxt    = move_count;
    tmr_nxt    = timer;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;
    to_nxt     = 1'b0;
    cell_sel   = 2'b11;
    for (int i = 0; i < 9; i++) begin
      if (move_pos == 4'(i)) cell_sel = board[2*i +: 2];
    end
    // move_pos values 9..15 leave cell_sel at 11, which is never empty
    legal = (cell_sel == 2'b00);

    if (new_game) begin
      state_nxt  = WAIT_MOVE;
      board_nxt  = '0;
      cur_nxt    = P_FIRST;
      winner_nxt = 2'b00;
      draw_nxt   = 1'b0;
      over_nxt   = 1'b0;
      cnt_nxt    = '0;
      tmr_nxt    = '0;
    end else begin
      case (state)
        WAIT_MOVE: begin
          if (move_valid) begin
            if (legal) begin
              for (int i = 0; i < 9; i++) begin
                if (move_pos == 4'(i)) board_nxt[2*i +: 2] = current_player;
              end
              cnt_nxt   = (move_count < 4'd9) ? move_count + 4'd1 : move_count;
              ack_nxt   = 1'b1;
              state_nxt = CHECK;
            end else begin
              err_nxt = 1'b1;
            end
            // A move on the expiry cycle wins; hold the timer so the next
            // idle cycle still forfeits if the move was rejected.
            if (TIMEOUT_CYCLES > 0 && timer != TMR_LAST) tmr_nxt = timer + 1'b1;
          end else if (TIMEOUT_CYCLES > 0) begin
            if (timer == TMR_LAST) begin
              to_nxt  = 1'b1;
              cur_nxt = other(current_player);
              tmr_nxt = '0;
            end else begin
              tmr_nxt = timer + 1'b1;
            end
          end
        end
        CHECK: begin
          if (any_line(board)) begin
            winner_nxt = current_player;
            over_nxt   = 1'b1;
            state_nxt  = OVER;
          end else if (move_count == 4'd9) begin
            draw_nxt  = 1'b1;
            over_nxt  = 1'b1;
            state_nxt = OVER;
          end else begin
            cur_nxt   = other(current_player);
            tmr_nxt   = '0;
            state_nxt = WAIT_MOVE;
          end
        end
        OVER: begin
          if (move_valid) err_nxt = 1'b1;
        end
        default: state_nxt = WAIT_MOVE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_MOVE;
    else        state <= state_nxt;
  end

  // Board, status, counters and output pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board          <= '0;
      current_player <= P_FIRST;
      winner         <= 2'b00;
      draw           <= 1'b0;
      game_over      <= 1'b0;
      move_count     <= '0;
      timer          <= '0;
      move_ack       <= 1'b0;
      move_err       <= 1'b0;
      turn_timeout   <= 1'b0;
    end else begin
      board          <= board_nxt;
      current_player <= cur_nxt;
      winner         <= winner_nxt;
      draw           <= draw_nxt;
      game_over      <= over_nxt;
      move_count     <= cnt_nxt;
      timer          <= tmr_nxt;
      move_ack       <= ack_nxt;
      move_err       <= err_nxt;
      turn_timeout   <= to_nxt;
    end
  end

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Directed bench for ttt_turn_controller: one instance without timeout for
// game play, one with TIMEOUT_CYCLES = 4 for turn forfeits.
module tb_ttt_turn_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game, move_valid;
  logic [3:0]  move_pos;
  logic [17:0] board;
  logic [1:0]  current_player, winner;
  logic        draw, game_over, move_ack, move_err, turn_timeout;

  logic        ng_t, mv_t;
  logic [3:0]  pos_t;
  logic [17:0] board_t;
  logic [1:0]  cp_t, winner_t;
  logic        draw_t, over_t, ack_t, err_t, to_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ttt_turn_controller #(.FIRST_PLAYER(1), .TIMEOUT_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos), .board(board), .current_player(current_player),
    .winner(winner), .draw(draw), .game_over(game_over), .move_ack(move_ack),
    .move_err(move_err), .turn_timeout(turn_timeout)
  );

  ttt_turn_controller #(.FIRST_PLAYER(1), .TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .reset(reset), .new_game(ng_t), .move_valid(mv_t),
    .move_pos(pos_t), .board(board_t), .current_player(cp_t),
    .winner(winner_t), .draw(draw_t), .game_over(over_t), .move_ack(ack_t),
    .move_err(err_t), .turn_timeout(to_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move on the untimed instance; checks ack, then steps past CHECK.
  task automatic play(input logic [3:0] pos);
    move_valid = 1'b1;
    move_pos   = pos;
    @(negedge clk);
    move_valid = 1'b0;
    chk("play_ack", move_ack, 1'b1);
    @(negedge clk);
  endtask

  task automatic restart();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic restart_t();
    ng_t = 1'b1;
    @(negedge clk);
    ng_t = 1'b0;
  endtask

  initial begin
    reset = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
    ng_t = 1'b0; mv_t = 1'b0; pos_t = 4'd0;
    @(negedge clk); @(negedge clk);
    chk("rst_board", board, 18'h0);
    chk("rst_cp", current_player, 2'b01);
    chk("rst_over", game_over, 1'b0);
    chk("rst_pulses", {move_ack, move_err, turn_timeout}, 3'b000);
    reset = 1'b1;
    @(negedge clk);

    // First move into the centre
    move_valid = 1'b1; move_pos = 4'd4;
    @(negedge clk);
    move_valid = 1'b0;
    chk("c4_ack", move_ack, 1'b1);
    chk("c4_board", board, 18'h00100);
    chk("c4_cp_hold", current_player, 2'b01);
    @(negedge clk);
    chk("c4_ack_drop", move_ack, 1'b0);
    chk("c4_cp_toggle", current_player, 2'b10);

    // X wins along the top row
    restart();
    chk("ng_board", board, 18'h0);
    chk("ng_cp", current_player, 2'b01);
    play(4'd0); play(4'd3); play(4'd1); play(4'd4);
    chk("win_pre_over", game_over, 1'b0);
    chk("win_pre_cp", current_player, 2'b01);
    play(4'd2);
    chk("win_winner", winner, 2'b01);
    chk("win_over", game_over, 1'b1);
    chk("win_cp", current_player, 2'b01);
    chk("win_board", board, 18'h00295);
    move_valid = 1'b1; move_pos = 4'd5;
    @(negedge clk);
    move_valid = 1'b0;
    chk("over_err", move_err, 1'b1);
    chk("over_ack", move_ack, 1'b0);
    chk("over_board", board, 18'h00295);

    // Full board, no line
    restart();
    play(4'd0); play(4'd1); play(4'd2); play(4'd4);
    play(4'd3); play(4'd5); play(4'd7); play(4'd6);
    chk("draw_pre", {draw, game_over}, 2'b00);
    play(4'd8);
    chk("draw_flag", draw, 1'b1);
    chk("draw_winner", winner, 2'b00);
    chk("draw_over", game_over, 1'b1);
    chk("draw_board", board, 18'h16A59);

    // Illegal moves: occupied, 9, 15
    restart();
    play(4'd4);
    move_valid = 1'b1; move_pos = 4'd4;
    @(negedge clk);
    chk("occ_err", move_err, 1'b1);
    chk("occ_ack", move_ack, 1'b0);
    move_pos = 4'd9;
    @(negedge clk);
    chk("p9_err", move_err, 1'b1);
    move_pos = 4'd15;
    @(negedge clk);
    move_valid = 1'b0;
    chk("p15_err", move_err, 1'b1);
    chk("ill_board", board, 18'h00100);
    chk("ill_cp", current_player, 2'b10);
    @(negedge clk);
    chk("ill_err_drop", move_err, 1'b0);

    // Timeout: four idle cycles forfeit the turn once
    restart_t();
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("to_early", to_t, 1'b0);
    chk("to_early_cp", cp_t, 2'b01);
    @(negedge clk);
    chk("to_fire", to_t, 1'b1);
    chk("to_cp", cp_t, 2'b10);
    chk("to_board", board_t, 18'h0);
    @(negedge clk);
    chk("to_once", to_t, 1'b0);
    chk("to_cp_hold", cp_t, 2'b10);

    // Move on the expiry cycle takes priority
    restart_t();
    @(negedge clk); @(negedge clk); @(negedge clk);
    mv_t = 1'b1; pos_t = 4'd0;
    @(negedge clk);
    mv_t = 1'b0;
    chk("exp_ack", ack_t, 1'b1);
    chk("exp_no_to", to_t, 1'b0);
    chk("exp_board", board_t, 18'h00001);
    @(negedge clk);
    chk("exp_no_to2", to_t, 1'b0);
    chk("exp_cp", cp_t, 2'b10);

    // A rejected move keeps the timer running
    restart_t();
    @(negedge clk);
    mv_t = 1'b1; pos_t = 4'd9;
    @(negedge clk);
    mv_t = 1'b0;
    chk("rej_err", err_t, 1'b1);
    @(negedge clk);
    chk("rej_no_to", to_t, 1'b0);
    @(negedge clk);
    chk("rej_to", to_t, 1'b1);

    // new_game beats a simultaneous move
    move_valid = 1'b1; move_pos = 4'd0; new_game = 1'b1;
    @(negedge clk);
    move_valid = 1'b0; new_game = 1'b0;
    chk("ngmv_board", board, 18'h0);
    chk("ngmv_pulses", {move_ack, move_err}, 2'b00);
    chk("ngmv_cp", current_player, 2'b01);

    // Asynchronous reset while in CHECK
    move_valid = 1'b1; move_pos = 4'd4;
    @(negedge clk);
    move_valid = 1'b0;
    chk("pre_rst_ack", move_ack, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_board", board, 18'h0);
    chk("arst_ack", move_ack, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_board", board, 18'h0);
    chk("post_rst_cp", current_player, 2'b01);
    chk("post_rst_stat", {winner, draw, game_over}, 4'b0000);
    chk("post_rst_pulses", {move_ack, move_err, turn_timeout}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
